// File: rtl/serial_full_adder_if.sv
// Operand/result bundle for serial_full_adder; the sub port exists only when
// SERIAL_SUB_EN is defined.
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one registered full-adder cell, LSB first, one bit per clock.
// Define SERIAL_SUB_EN to add a sub input that turns the block into a subtractor.
module serial_full_adder #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                rst,
    serial_full_adder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    count;
    logic             carry;
    logic             busy_reg;
    logic             done_reg;
    logic             cout_reg;
    logic             bit_sum;
    logic             carry_next;
    logic             invert;
    logic             inverting;

`ifdef SERIAL_SUB_EN
    logic sub_reg;
    assign invert    = bus.sub;
    assign inverting = sub_reg;
`else
    assign invert    = 1'b0;
    assign inverting = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        bit_sum    = 1'b0;
        carry_next = 1'b0;
        bit_sum    = opa[0] ^ opb[0] ^ carry;
        carry_next = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opa      <= '0;
            opb      <= '0;
            sum_reg  <= '0;
            count    <= '0;
            carry    <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            cout_reg <= 1'b0;
`ifdef SERIAL_SUB_EN
            sub_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + ~borrow through the same cell.
                        opa      <= bus.a;
                        opb      <= bus.b ^ {WIDTH{invert}};
                        carry    <= bus.cin ^ invert;
                        count    <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
`ifdef SERIAL_SUB_EN
                        sub_reg  <= bus.sub;
`endif
                    end
                end
                RUN: begin
                    sum_reg <= {bit_sum, sum_reg[WIDTH-1:1]};
                    opa     <= opa >> 1;
                    opb     <= opb >> 1;
                    carry   <= carry_next;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        cout_reg <= carry_next ^ inverting;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: directed cases, random operands at
// WIDTH=8 and an exhaustive sweep at WIDTH=3, all against an arithmetic model.
module tb_serial_full_adder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_full_adder_if #(.WIDTH(8)) i8 ();
    serial_full_adder_if #(.WIDTH(3)) i3 ();

    serial_full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8.slave));
    serial_full_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(i3.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {carry/borrow, result} from plain integer arithmetic.
    function automatic logic [8:0] model8(input int a, input int b, input int cin, input int sub);
        int r;
        if (sub != 0) begin
            r = a - b - cin;
            return {r < 0, 8'(r)};
        end
        r = a + b + cin;
        return 9'(r);
    endfunction

    task automatic drive_sub8(input logic s);
`ifdef SERIAL_SUB_EN
        i8.sub = s;
`else
        if (s) $display("sub requested in an add-only build");
`endif
    endtask

    // One operation on the 8-bit DUT. poke >= 0 forces start with a=AA at that RUN cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input int poke, input string tag);
        logic [8:0] exp;
        int         lat;
        bit         seen;
        exp = model8(int'(a), int'(b), int'(cin), int'(sub));
        @(negedge clk);
        i8.start = 1'b1; i8.a = a; i8.b = b; i8.cin = cin; drive_sub8(sub);
        @(posedge clk); #1;
        check({tag, "/busy_run"}, i8.busy, 1);
        lat  = 0;
        seen = 0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            i8.start = (lat == poke) ? 1'b1 : 1'($urandom);
            i8.a     = (lat == poke) ? 8'hAA : 8'($urandom);
            i8.b     = 8'($urandom);
            i8.cin   = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            seen = i8.done;
        end
        check({tag, "/latency"}, lat, 8);
        check({tag, "/sum"}, i8.sum, exp[7:0]);
        check({tag, "/cout"}, i8.cout, exp[8]);
        check({tag, "/busy_done"}, i8.busy, 1);
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'($urandom); i8.b = 8'($urandom);
        @(posedge clk); #1;
        check({tag, "/idle_busy"}, i8.busy, 0);
        check({tag, "/idle_done"}, i8.done, 0);
        @(negedge clk);
        i8.start = 1'b0;
    endtask

    initial begin
        int         lat;
        int         ndone;
        logic [3:0] exp3;
        logic [7:0] ra;
        logic [7:0] rb;

        i8.start = 0; i8.a = '0; i8.b = '0; i8.cin = 0;
        i3.start = 0; i3.a = '0; i3.b = '0; i3.cin = 0;
`ifdef SERIAL_SUB_EN
        i8.sub = 0; i3.sub = 0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", i8.busy, 0);
        check("reset/done", i8.done, 0);
        check("reset/sum", i8.sum, 0);
        check("reset/cout", i8.cout, 0);
        check("reset3/sum", {i3.cout, i3.sum}, 0);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h3C, 8'h0F, 1'b0, 1'b0, -1, "basic");
        run8(8'hFF, 8'h01, 1'b0, 1'b0, -1, "carry1");
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, -1, "carry2");
        run8(8'h10, 8'h20, 1'b0, 1'b0, 2, "busy_start");

        // Abort with rst after edge 4 of an operation.
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'h55; i8.b = 8'h55; i8.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort/busy", i8.busy, 0);
        check("abort/done", i8.done, 0);
        check("abort/sum", i8.sum, 0);
        check("abort/cout", i8.cout, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (i8.done) ndone++;
        end
        check("abort/no_done", ndone, 0);
        run8(8'h55, 8'h55, 1'b0, 1'b0, -1, "after_abort");

        repeat (20) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 1'($urandom), 1'b0, int'($urandom_range(0, 9)), "rand_add");
        end

`ifdef SERIAL_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, -1, "sub1");
        run8(8'h07, 8'h05, 1'b1, 1'b1, -1, "sub2");
        repeat (20) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 1'($urandom), 1'($urandom), -1, "rand_mix");
        end
`endif

        // Exhaustive sweep of the 3-bit instance, back to back.
        for (int ea = 0; ea < 8; ea++) begin
            for (int eb = 0; eb < 8; eb++) begin
                for (int ec = 0; ec < 2; ec++) begin
                    exp3 = 4'(ea + eb + ec);
                    @(negedge clk);
                    i3.start = 1'b1; i3.a = 3'(ea); i3.b = 3'(eb); i3.cin = 1'(ec);
                    @(posedge clk);
                    @(negedge clk);
                    i3.start = 1'b0;
                    lat = 0;
                    while (lat < 20 && !i3.done) begin
                        @(posedge clk); #1;
                        lat++;
                    end
                    check("exh3/latency", lat, 3);
                    check("exh3/result", {i3.cout, i3.sum}, exp3);
                    @(posedge clk);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
